xpb_lut_bank: RTL and testbench
===============================

Name: xpb_lut_bank

Overview:
Parametrised successor to the fixed xpb constant tables used in modular_square reduction. Holds one table of 2^IDX_W precomputed DATA_W-bit xpb residues. The table is loaded at runtime over a narrow streaming bus, so the modulus can change without resynthesis. The table serves NUM_LANES independent lookups per cycle with registered, valid-qualified outputs. Entry 0 is hardwired to zero.

Parameters:
IDX_W, 5, index width; the table has 2^IDX_W entries (entry 0 is constant zero, not stored)
DATA_W, 1024, width of each table entry
LOAD_W, 32, load bus width; DATA_W must be a multiple of LOAD_W (elaboration error otherwise)
NUM_LANES, 4, number of parallel lookup ports

Ports:
clk  input  1  clock; all logic on rising edge
rst_n  input  1  asynchronous active-low reset
load_start  input  1  pulse; begins (or restarts) a table load
load_valid  input  1  load word valid
load_data  input  LOAD_W  load word
load_ready  output  1  high while the block accepts load words
table_ready  output  1  high when a complete table is resident
lk_valid  input  NUM_LANES  per-lane lookup request
lk_idx  input  NUM_LANES*IDX_W  per-lane index; lane n at [n*IDX_W +: IDX_W]
lk_data  output  NUM_LANES*DATA_W  per-lane result; lane n at [n*DATA_W +: DATA_W]
lk_out_valid  output  NUM_LANES  per-lane result valid
lk_err  output  1  one-cycle pulse: lookup requested while table_ready=0

Behaviour:
- Reset (async assert, sync release): state=IDLE; load_ready, table_ready, lk_out_valid and lk_err = 0; lk_data = 0; load counters = 0. Table storage is not reset; its contents are meaningless until table_ready=1.
- States:
  - IDLE: no table. load_start -> LOAD.
  - LOAD: load_ready=1. Last word of the last entry accepted -> READY.
  - READY: table_ready=1. load_start -> LOAD.
- Load order: entries 1 .. 2^IDX_W-1 in ascending order. Each entry takes WPE = DATA_W/LOAD_W words, least-significant word first; word j fills bits [j*LOAD_W +: LOAD_W]. A complete load is (2^IDX_W-1)*WPE handshakes (992 at defaults).
- A word is accepted when load_valid && load_ready. Cycles with load_valid=0 do not advance the counters.
- Entries are assembled in a DATA_W shift/assembly register. The entry is committed to storage on the cycle its last word is accepted.
- On entering LOAD: word and entry counters clear; table_ready drops on the next edge. load_ready rises on the edge after load_start.
- table_ready rises on the edge after the final handshake. load_ready falls on that same edge.
- load_start while in LOAD restarts the load from entry 1, word 0. Partially written entries are overwritten by the new load.
- load_start and load_valid in the same cycle: load_start wins and the word is dropped.
- Lookup, per lane, independent of the other lanes:
  - If lk_valid[n] && table_ready: on the next edge, lk_data lane n = table[lk_idx lane n] and lk_out_valid[n] = 1. Latency is 1 cycle, fully pipelined, one lookup per lane per cycle.
  - lk_idx = 0 returns all-zero.
  - Any number of lanes may request the same index in the same cycle.
  - When lk_valid[n]=0, lk_out_valid[n]=0 and lk_data lane n holds its previous value.
- Lookup with table_ready=0: on the next edge, lk_out_valid for that lane = 0, lk_data lane unchanged, and lk_err = 1 for one cycle (a single OR across lanes).
- Lookup in the same cycle as the final load handshake: table_ready is still 0, so this is an error.
- Lookup in the same cycle as a load_start from READY: served from the old table (table_ready is still 1 that cycle).
- Reset mid-load: immediate return to IDLE; a full reload is required.

Test Plan:
- Reset -> hold rst_n=0 for 3 cycles, then release. Required: lk_data=0, lk_out_valid=0, load_ready=0, table_ready=0, lk_err=0.
- Full load at defaults -> word j of entry e = {8'(e), 8'(j), 16'hA5A5}, 992 back-to-back words. Required: table_ready=1 exactly one cycle after the 992nd handshake, load_ready=0 on that same edge.
- Lookup after load -> in one cycle, lane0 idx=1, lane1 idx=0, lane2 idx=17, lane3 idx=31. Required on the next cycle: lk_out_valid=4'b1111, lane1 = 0, lane3 bits[31:0] = 32'h1F00A5A5, lane3 bits[1023:992] = 32'h1F1FA5A5.
- Throttled load -> load_valid toggled with a random ~50% duty. Required: same final contents as the back-to-back load; counters advance only on handshakes.
- Restart and error -> load_start after 100 accepted words, then lane2 lookup idx=5. Required: table_ready stays 0, load restarts at entry 1 word 0, lk_err pulses one cycle, lk_out_valid=0. Then a full reload gives correct data.
- Async reset mid-load -> assert rst_n=0 between clock edges after 500 words. Required: load_ready=0 immediately. After release the state is IDLE, and a lookup gives lk_err=1.

Source files
------------

// File: rtl/xpb_lut_bank.sv
// ============================================================================
// Module   : xpb_lut_bank
// Purpose  : Runtime-loadable table of xpb residues with NUM_LANES registered,
//            valid-qualified lookup ports. Entry 0 reads as constant zero.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module xpb_lut_bank #(
    parameter int IDX_W     = 5,
    parameter int DATA_W    = 1024,
    parameter int LOAD_W    = 32,
    parameter int NUM_LANES = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          load_start,
    input  logic                          load_valid,
    input  logic [LOAD_W-1:0]             load_data,
    output logic                          load_ready,
    output logic                          table_ready,
    input  logic [NUM_LANES-1:0]          lk_valid,
    input  logic [NUM_LANES*IDX_W-1:0]    lk_idx,
    output logic [NUM_LANES*DATA_W-1:0]   lk_data,
    output logic [NUM_LANES-1:0]          lk_out_valid,
    output logic                          lk_err
);

    localparam int c_WPE     = DATA_W / LOAD_W;
    localparam int c_NUM_ENT = 1 << IDX_W;
    localparam int c_WCNT_W  = (c_WPE > 1) ? $clog2(c_WPE) : 1;

    if ((DATA_W % LOAD_W) != 0) begin : g_bad_load_w
        $error("xpb_lut_bank: DATA_W must be a multiple of LOAD_W");
    end
    if (IDX_W < 1 || NUM_LANES < 1) begin : g_bad_shape
        $error("xpb_lut_bank: IDX_W and NUM_LANES must be at least 1");
    end

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_READY = 2'd2
    } state_t;

    state_t                r_state;
    logic                  r_load_ready;
    logic                  r_table_ready;
    logic [c_WCNT_W-1:0]   r_word_cnt;
    logic [IDX_W-1:0]      r_entry_cnt;
    logic                  r_lk_err;

    logic [DATA_W-1:0]     r_asm;
    logic [DATA_W-1:0]     r_mem [1:c_NUM_ENT-1];

    logic                  w_accept;
    logic                  w_last_word;
    logic                  w_last_entry;
    logic [DATA_W-1:0]     w_asm_next;

    // load_start has priority: a word presented alongside it is dropped
    assign w_accept     = (r_state == ST_LOAD) && load_valid && !load_start;
    assign w_last_word  = (r_word_cnt == c_WCNT_W'(c_WPE - 1));
    assign w_last_entry = (r_entry_cnt == {IDX_W{1'b1}});

    // Words arrive LS-first, so shifting right leaves word j at [j*LOAD_W +: LOAD_W]
    if (c_WPE == 1) begin : g_asm_single
        assign w_asm_next = load_data;
    end else begin : g_asm_multi
        assign w_asm_next = {load_data, r_asm[DATA_W-1:LOAD_W]};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= ST_IDLE;
            r_load_ready  <= 1'b0;
            r_table_ready <= 1'b0;
            r_word_cnt    <= '0;
            r_entry_cnt   <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (load_start) begin
                        r_state      <= ST_LOAD;
                        r_load_ready <= 1'b1;
                        r_word_cnt   <= '0;
                        r_entry_cnt  <= IDX_W'(1);
                    end
                end
                ST_LOAD: begin
                    if (load_start) begin
                        r_word_cnt  <= '0;
                        r_entry_cnt <= IDX_W'(1);
                    end else if (w_accept) begin
                        if (w_last_word) begin
                            r_word_cnt <= '0;
                            if (w_last_entry) begin
                                r_state       <= ST_READY;
                                r_load_ready  <= 1'b0;
                                r_table_ready <= 1'b1;
                                r_entry_cnt   <= '0;
                            end else begin
                                r_entry_cnt <= r_entry_cnt + IDX_W'(1);
                            end
                        end else begin
                            r_word_cnt <= r_word_cnt + c_WCNT_W'(1);
                        end
                    end
                end
                ST_READY: begin
                    if (load_start) begin
                        r_state       <= ST_LOAD;
                        r_load_ready  <= 1'b1;
                        r_table_ready <= 1'b0;
                        r_word_cnt    <= '0;
                        r_entry_cnt   <= IDX_W'(1);
                    end
                end
                default: begin
                    r_state       <= ST_IDLE;
                    r_load_ready  <= 1'b0;
                    r_table_ready <= 1'b0;
                end
            endcase
        end
    end

    // Table storage is deliberately unreset; table_ready qualifies its contents
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_asm <= w_asm_next;
            if (w_last_word) begin
                r_mem[r_entry_cnt] <= w_asm_next;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lk_err <= 1'b0;
        end else begin
            r_lk_err <= (|lk_valid) && !r_table_ready;
        end
    end

    for (genvar n = 0; n < NUM_LANES; n++) begin : g_lane
        logic [IDX_W-1:0]  w_idx;
        logic [DATA_W-1:0] w_rd;
        logic [DATA_W-1:0] r_data;
        logic              r_out_valid;

        assign w_idx = lk_idx[n*IDX_W +: IDX_W];
        assign w_rd  = (w_idx == '0) ? '0 : r_mem[w_idx];

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_data      <= '0;
                r_out_valid <= 1'b0;
            end else begin
                r_out_valid <= lk_valid[n] && r_table_ready;
                if (lk_valid[n] && r_table_ready) begin
                    r_data <= w_rd;
                end
            end
        end

        assign lk_data[n*DATA_W +: DATA_W] = r_data;
        assign lk_out_valid[n]             = r_out_valid;
    end

    assign load_ready  = r_load_ready;
    assign table_ready = r_table_ready;
    assign lk_err      = r_lk_err;

endmodule

`default_nettype wire

// File: tb/tb_xpb_lut_bank.sv
// ============================================================================
// Module   : tb_xpb_lut_bank
// Purpose  : Self-checking bench for xpb_lut_bank (default parameters).
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_xpb_lut_bank;

    localparam int IDX_W = 5;
    localparam int DW    = 1024;
    localparam int LW    = 32;
    localparam int NL    = 4;

    logic              clk;
    logic              rst_n;
    logic              load_start;
    logic              load_valid;
    logic [LW-1:0]     load_data;
    wire               load_ready;
    wire               table_ready;
    logic [NL-1:0]     lk_valid;
    logic [NL*IDX_W-1:0] lk_idx;
    wire  [NL*DW-1:0]  lk_data;
    wire  [NL-1:0]     lk_out_valid;
    wire               lk_err;

    xpb_lut_bank #(.IDX_W(IDX_W), .DATA_W(DW), .LOAD_W(LW), .NUM_LANES(NL)) dut (
        .clk(clk), .rst_n(rst_n),
        .load_start(load_start), .load_valid(load_valid), .load_data(load_data),
        .load_ready(load_ready), .table_ready(table_ready),
        .lk_valid(lk_valid), .lk_idx(lk_idx), .lk_data(lk_data),
        .lk_out_valid(lk_out_valid), .lk_err(lk_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [NL-1:0]    ov;
        logic             err;
        logic [NL*DW-1:0] data;
    } exp_t;

    typedef struct {
        logic [NL-1:0]       v;
        logic [NL*IDX_W-1:0] idx;
        logic [NL-1:0]       exp_ov;
        logic                exp_err;
    } vec_t;

    exp_t             sbq[$];
    logic [NL*DW-1:0] exp_hold;
    bit               model_ready;
    logic [31:0]      salt;
    int               tb_e, tb_j;
    int               total, bad;

    function automatic logic [31:0] word_of(int e, int j);
        logic [7:0] e8, j8;
        e8 = 8'(e);
        j8 = 8'(j);
        return {e8, j8, 16'hA5A5} ^ salt;
    endfunction

    function automatic logic [DW-1:0] entry_val(int e);
        logic [DW-1:0] v;
        logic [7:0] e8, j8;
        v  = '0;
        e8 = 8'(e);
        if (e != 0) begin
            for (int j = 0; j < DW / LW; j++) begin
                j8 = 8'(j);
                v[j*LW +: LW] = {e8, j8, 16'hA5A5};
            end
        end
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    task automatic chk_data(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        int k;
        total++;
        if (act !== exp) begin
            bad++;
            k = 0;
            for (int w = DW / LW - 1; w >= 0; w--)
                if (act[w*LW +: LW] !== exp[w*LW +: LW]) k = w;
            $display("FAIL %s: word %0d got %h, want %h", name, k, act[k*LW +: LW], exp[k*LW +: LW]);
        end
    endtask

    task automatic drive_lookup(input logic [NL-1:0] v, input logic [NL*IDX_W-1:0] idx);
        exp_t x;
        lk_valid = v;
        lk_idx   = idx;
        for (int n = 0; n < NL; n++)
            if (v[n] && model_ready)
                exp_hold[n*DW +: DW] = entry_val(int'(idx[n*IDX_W +: IDX_W]));
        x.ov   = model_ready ? v : '0;
        x.err  = (|v) && !model_ready;
        x.data = exp_hold;
        sbq.push_back(x);
    endtask

    task automatic check_lookup(input string tag);
        exp_t x;
        lk_valid = '0;
        if (sbq.size() == 0) begin
            total++; bad++;
            $display("FAIL %s: scoreboard empty, got ov=%b", tag, lk_out_valid);
        end else begin
            x = sbq.pop_front();
            chk({tag, ".ov"},  32'(lk_out_valid), 32'(x.ov));
            chk({tag, ".err"}, 32'(lk_err),       32'(x.err));
            for (int n = 0; n < NL; n++)
                chk_data($sformatf("%s.lane%0d", tag, n), lk_data[n*DW +: DW], x.data[n*DW +: DW]);
        end
    endtask

    task automatic start_load();
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
        tb_e = 1;
        tb_j = 0;
        model_ready = 1'b0;
    endtask

    task automatic load_words(input int n, input bit thr);
        int acc, cyc;
        bit hs;
        acc = 0;
        cyc = 0;
        while (acc < n && cyc < 5000) begin
            load_valid = thr ? 1'($urandom_range(0, 1)) : 1'b1;
            load_data  = word_of(tb_e, tb_j);
            hs = load_valid && load_ready;
            tick();
            cyc++;
            if (hs) begin
                acc++;
                if (tb_j == DW / LW - 1) begin
                    tb_j = 0;
                    tb_e++;
                end else begin
                    tb_j++;
                end
            end
        end
        load_valid = 1'b0;
        if (acc < n) begin
            total++; bad++;
            $display("FAIL load_timeout: got %0d handshakes, want %0d", acc, n);
        end
    endtask

    vec_t vecs[6];

    initial begin
        total = 0; bad = 0;
        salt = '0; model_ready = 1'b0; exp_hold = '0;
        tb_e = 1; tb_j = 0;
        rst_n = 1'b0; load_start = 1'b0; load_valid = 1'b0; load_data = '0;
        lk_valid = '0; lk_idx = '0;

        vecs[0] = '{4'b1111, {5'd31, 5'd17, 5'd0, 5'd1},  4'b1111, 1'b0};
        vecs[1] = '{4'b1111, {5'd31, 5'd31, 5'd31, 5'd31}, 4'b1111, 1'b0};
        vecs[2] = '{4'b0101, {5'd0, 5'd30, 5'd9, 5'd2},    4'b0101, 1'b0};
        vecs[3] = '{4'b0000, {5'd3, 5'd3, 5'd3, 5'd3},     4'b0000, 1'b0};
        vecs[4] = '{4'b1111, {5'd0, 5'd0, 5'd0, 5'd0},     4'b1111, 1'b0};
        vecs[5] = '{4'b1010, {5'd8, 5'd1, 5'd15, 5'd16},   4'b1010, 1'b0};

        repeat (3) tick();
        chk("rst.lk_data0", lk_data[31:0], 32'h0);
        chk("rst.lk_out_valid", 32'(lk_out_valid), 32'h0);
        chk("rst.load_ready", 32'(load_ready), 32'h0);
        chk("rst.table_ready", 32'(table_ready), 32'h0);
        chk("rst.lk_err", 32'(lk_err), 32'h0);
        rst_n = 1'b1;
        tick();

        drive_lookup(4'b0001, {5'd0, 5'd0, 5'd0, 5'd1});
        tick();
        check_lookup("idle_lookup");

        start_load();
        chk("load.ready_rise", 32'(load_ready), 32'h1);
        load_words(991, 1'b0);
        chk("load.not_yet_ready", 32'(table_ready), 32'h0);
        // Final handshake with a concurrent lookup: still an error cycle
        load_valid = 1'b1;
        load_data  = word_of(tb_e, tb_j);
        drive_lookup(4'b0001, {5'd0, 5'd0, 5'd0, 5'd3});
        tick();
        load_valid = 1'b0;
        check_lookup("final_hs_lookup");
        chk("load.table_ready", 32'(table_ready), 32'h1);
        chk("load.load_ready_fall", 32'(load_ready), 32'h0);
        model_ready = 1'b1;

        for (int i = 0; i < 6; i++) begin
            drive_lookup(vecs[i].v, vecs[i].idx);
            tick();
            chk($sformatf("vec%0d.table_ov", i), 32'(lk_out_valid), 32'(vecs[i].exp_ov));
            chk($sformatf("vec%0d.table_err", i), 32'(lk_err), 32'(vecs[i].exp_err));
            if (i == 0) begin
                chk("vec0.lane1_zero", lk_data[DW +: 32], 32'h0);
                chk("vec0.lane3_lo", lk_data[3*DW +: 32], 32'h1F00A5A5);
                chk("vec0.lane3_hi", lk_data[3*DW + 992 +: 32], 32'h1F1FA5A5);
            end
            check_lookup($sformatf("vec%0d", i));
        end

        // Lookup alongside load_start from READY uses the old table
        load_start = 1'b1;
        drive_lookup(4'b0010, {5'd0, 5'd0, 5'd7, 5'd0});
        tick();
        load_start = 1'b0;
        check_lookup("start_from_ready");
        tb_e = 1; tb_j = 0; model_ready = 1'b0;
        chk("reload.table_drop", 32'(table_ready), 32'h0);
        chk("reload.load_ready", 32'(load_ready), 32'h1);

        salt = 32'h5A5A_5A5A;
        load_words(100, 1'b1);
        start_load();
        chk("restart.table_ready", 32'(table_ready), 32'h0);
        drive_lookup(4'b0100, {5'd0, 5'd5, 5'd0, 5'd0});
        tick();
        check_lookup("restart_err");
        salt = '0;
        load_words(992, 1'b1);
        chk("thr.table_ready", 32'(table_ready), 32'h1);
        chk("thr.load_ready", 32'(load_ready), 32'h0);
        model_ready = 1'b1;
        drive_lookup(4'b1111, {5'd4, 5'd3, 5'd2, 5'd1});
        tick();
        check_lookup("thr_a");
        drive_lookup(4'b1111, {5'd0, 5'd31, 5'd30, 5'd5});
        tick();
        check_lookup("thr_b");

        start_load();
        load_words(500, 1'b0);
        #3 rst_n = 1'b0;
        #1;
        chk("arst.load_ready", 32'(load_ready), 32'h0);
        chk("arst.table_ready", 32'(table_ready), 32'h0);
        chk("arst.lk_data3", lk_data[3*DW +: 32], 32'h0);
        exp_hold = '0;
        model_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        tick();
        chk("arst.idle_load_ready", 32'(load_ready), 32'h0);
        drive_lookup(4'b1000, {5'd9, 5'd0, 5'd0, 5'd0});
        tick();
        check_lookup("arst_lookup");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
